// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: shares the memory bus between the CPU and the sprite (OAM) DMA engine.
// A CPU write to DMA_REG_ADDR copies 256 bytes from page {data,8'h00} to OAM_DATA_ADDR
// while holding the CPU halted. Reads always land on get (parity 0) cycles.
// Optional: define OAMDMA_DEBUG_PORTS_EN to expose dma_busy, dma_index and dma_done.
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_data_out,
    output logic        cpu_halt,
    output logic [15:0] mem_addr,
    output logic        mem_rw,
    output logic [7:0]  mem_data_out,
    input  logic [7:0]  mem_data_in,
`ifdef OAMDMA_DEBUG_PORTS_EN
    output logic        dma_busy,
    output logic [7:0]  dma_index,
    output logic        dma_done,
`endif
    output logic [7:0]  cpu_data_in
);

    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StAlign,
        StRead,
        StWrite
    } state_e;

    state_e      state_q, state_d;
    logic        parity_q;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  data_buf_q, data_buf_d;
    logic        cpu_halt_q, cpu_halt_d;
    logic        trigger;

    assign trigger     = !cpu_rw && (cpu_addr == DMA_REG_ADDR);
    assign cpu_halt    = cpu_halt_q;
    assign cpu_data_in = mem_data_in;

    // Get/put cycle tracking: parity 0 is a get (read) cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ~parity_q;
        end
    end

    // State and DMA bookkeeping registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= 8'h00;
            page_q     <= 8'h00;
            data_buf_q <= 8'h00;
            cpu_halt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            page_q     <= page_d;
            data_buf_q <= data_buf_d;
            cpu_halt_q <= cpu_halt_d;
        end
    end

    // Next-state logic and bus mux; IDLE is a pure passthrough of the CPU.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        page_d       = page_q;
        data_buf_d   = data_buf_q;
        cpu_halt_d   = cpu_halt_q;
        mem_addr     = cpu_addr;
        mem_rw       = cpu_rw;
        mem_data_out = cpu_data_out;

        unique case (state_q)
            StIdle: begin
                // The trigger write itself still reaches memory through the passthrough.
                if (trigger) begin
                    page_d     = cpu_data_out;
                    idx_d      = 8'h00;
                    cpu_halt_d = 1'b1;
                    state_d    = StHalt;
                end
            end
            StHalt: begin
                mem_rw       = 1'b1;
                mem_data_out = 8'h00;
                // Skip the alignment cycle when the next cycle is already a get cycle.
                state_d      = parity_q ? StRead : StAlign;
            end
            StAlign: begin
                mem_rw       = 1'b1;
                mem_data_out = 8'h00;
                state_d      = StRead;
            end
            StRead: begin
                mem_addr     = {page_q, idx_q};
                mem_rw       = 1'b1;
                mem_data_out = 8'h00;
                data_buf_d   = mem_data_in;
                state_d      = StWrite;
            end
            StWrite: begin
                mem_addr     = OAM_DATA_ADDR;
                mem_rw       = 1'b0;
                mem_data_out = data_buf_q;
                // idx wraps within the page; the page never carries.
                idx_d        = idx_q + 8'd1;
                if (idx_q == 8'hFF) begin
                    cpu_halt_d = 1'b0;
                    state_d    = StIdle;
                end else begin
                    state_d    = StRead;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef OAMDMA_DEBUG_PORTS_EN
    logic dma_done_q;

    // One-cycle pulse on the cycle after the final WRITE.
    always_ff @(posedge clock) begin
        if (reset) begin
            dma_done_q <= 1'b0;
        end else begin
            dma_done_q <= (state_q == StWrite) && (idx_q == 8'hFF);
        end
    end

    assign dma_busy  = (state_q != StIdle);
    assign dma_index = idx_q;
    assign dma_done  = dma_done_q;
`endif

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Testbench for oam_dma_arbiter: random memory image, a bus monitor, and a
// reference model built from the copy rules (256 bytes page->OAM, 513/514 halted cycles).
module tb_oam_dma_arbiter;

    localparam logic [15:0] DMA_REG = 16'h4014;
    localparam logic [15:0] OAM_REG = 16'h2004;
    localparam logic [15:0] PARK    = 16'h8000;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_data_out;
    logic        cpu_halt;
    logic [15:0] mem_addr;
    logic        mem_rw;
    logic [7:0]  mem_data_out;
    logic [7:0]  mem_data_in;
    logic [7:0]  cpu_data_in;
`ifdef OAMDMA_DEBUG_PORTS_EN
    logic        dma_busy;
    logic [7:0]  dma_index;
    logic        dma_done;
`endif

    oam_dma_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_rw       (cpu_rw),
        .cpu_data_out (cpu_data_out),
        .cpu_halt     (cpu_halt),
        .mem_addr     (mem_addr),
        .mem_rw       (mem_rw),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
`ifdef OAMDMA_DEBUG_PORTS_EN
        .dma_busy     (dma_busy),
        .dma_index    (dma_index),
        .dma_done     (dma_done),
`endif
        .cpu_data_in  (cpu_data_in)
    );

    always #5 clock = ~clock;

    // Read-only memory image; data is valid within the same cycle.
    logic [7:0] mem [0:65535];
    assign mem_data_in = mem[mem_addr];

    // Bench-side cycle counter: its LSB is the expected bus parity.
    logic [31:0] cyc;
    always @(posedge clock) begin
        if (reset) cyc <= 32'd0;
        else       cyc <= cyc + 32'd1;
    end

    // Bus monitor, sampled mid-cycle.
    logic [7:0]  wr_data [$];
    logic [15:0] rd_addr [$];
    bit          rd_par [$];
    bit          wr_par [$];
    int          halt_cnt;
    int          done_cnt;
    bit          saw_zero;
    logic [15:0] prev_addr;
    bit          prev_par;

    always @(negedge clock) begin
        if (!mem_rw && mem_addr == OAM_REG) begin
            wr_data.push_back(mem_data_out);
            rd_addr.push_back(prev_addr);
            rd_par.push_back(prev_par);
            wr_par.push_back(cyc[0]);
        end
        if (cpu_halt) halt_cnt++;
        if (cpu_halt && mem_addr == 16'h0000) saw_zero = 1'b1;
`ifdef OAMDMA_DEBUG_PORTS_EN
        if (dma_done) done_cnt++;
`endif
        prev_addr = mem_addr;
        prev_par  = cyc[0];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic clear_log();
        wr_data.delete();
        rd_addr.delete();
        rd_par.delete();
        wr_par.delete();
        halt_cnt = 0;
        done_cnt = 0;
        saw_zero = 1'b0;
    endtask

    task automatic park_cpu();
        cpu_addr     = PARK;
        cpu_rw       = 1'b1;
        cpu_data_out = 8'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        park_cpu();
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (cpu_halt !== 1'b0) $display("FAIL reset_halt: got %b want 0", cpu_halt);
        else n_pass++;
        n_checks++;
        if (mem_addr !== PARK || mem_rw !== 1'b1)
            $display("FAIL reset_passthrough: got %h/%b want %h/1", mem_addr, mem_rw, PARK);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_idle_passthrough();
        cpu_addr = 16'h0821;
        cpu_rw   = 1'b1;
        mem[16'h0821] = 8'h31;
        #1;
        n_checks++;
        if (mem_addr !== 16'h0821 || mem_rw !== 1'b1 || cpu_data_in !== 8'h31 || cpu_halt !== 1'b0)
            $display("FAIL idle_read: got %h/%b/%h/%b want 0821/1/31/0",
                     mem_addr, mem_rw, cpu_data_in, cpu_halt);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] a;
            logic        rw;
            logic [7:0]  d;
            @(posedge clock);
            #1;
            a  = 16'($urandom);
            rw = 1'($urandom);
            d  = 8'($urandom);
            if (a == DMA_REG) a = 16'h1234;
            cpu_addr = a;
            cpu_rw = rw;
            cpu_data_out = d;
            #1;
            n_checks++;
            if (mem_addr !== a || mem_rw !== rw || mem_data_out !== d || cpu_data_in !== mem[a])
                $display("FAIL idle_random: got %h/%b/%h/%h want %h/%b/%h/%h", mem_addr, mem_rw,
                         mem_data_out, cpu_data_in, a, rw, d, mem[a]);
            else n_pass++;
        end
        @(posedge clock);
        #1;
        park_cpu();
    endtask

    // Trigger a DMA on a chosen parity and check the whole copy against the model.
    task automatic run_dma(input logic [7:0] pg, input bit odd, input bit retrig,
                           input string name);
        int waited;
        int bad;
        int n;
        @(posedge clock);
        #1;
        if (cyc[0] != odd) begin
            @(posedge clock);
            #1;
        end
        clear_log();
        cpu_rw = 1'b0;
        cpu_addr = DMA_REG;
        cpu_data_out = pg;
        @(posedge clock);
        #1;
        park_cpu();
        waited = 0;
        while (cpu_halt && waited < 700) begin
            if (retrig && waited >= 5 && waited < 15) begin
                cpu_rw = 1'b0;
                cpu_addr = DMA_REG;
                cpu_data_out = 8'h05;
            end else begin
                park_cpu();
            end
            @(posedge clock);
            #1;
            waited++;
        end
        park_cpu();
        #1;
        n_checks++;
        if (waited >= 700) $display("FAIL %s_timeout: halt still %b after %0d cycles", name,
                                    cpu_halt, waited);
        else n_pass++;
        n_checks++;
        if (halt_cnt != 513 + int'(odd))
            $display("FAIL %s_halt_cycles: got %0d want %0d", name, halt_cnt, 513 + int'(odd));
        else n_pass++;
        n_checks++;
        if (wr_data.size() != 256)
            $display("FAIL %s_write_count: got %0d want 256", name, wr_data.size());
        else n_pass++;
        n = (wr_data.size() < 256) ? wr_data.size() : 256;
        bad = -1;
        for (int i = 0; i < n; i++)
            if (bad < 0 && wr_data[i] !== mem[{pg, 8'(i)}]) bad = i;
        n_checks++;
        if (bad >= 0) $display("FAIL %s_data: idx %0d got %h want %h", name, bad, wr_data[bad],
                               mem[{pg, 8'(bad)}]);
        else n_pass++;
        bad = -1;
        for (int i = 0; i < n; i++)
            if (bad < 0 && rd_addr[i] !== {pg, 8'(i)}) bad = i;
        n_checks++;
        if (bad >= 0) $display("FAIL %s_src_addr: idx %0d got %h want %h", name, bad,
                               rd_addr[bad], {pg, 8'(bad)});
        else n_pass++;
        bad = -1;
        for (int i = 0; i < n; i++)
            if (bad < 0 && (rd_par[i] != 1'b0 || wr_par[i] != 1'b1)) bad = i;
        n_checks++;
        if (bad >= 0) $display("FAIL %s_parity: idx %0d got read %b write %b want 0 1", name,
                               bad, rd_par[bad], wr_par[bad]);
        else n_pass++;
        n_checks++;
        if (cpu_halt !== 1'b0 || mem_addr !== PARK || mem_rw !== 1'b1)
            $display("FAIL %s_release: got %b/%h/%b want 0/%h/1", name, cpu_halt, mem_addr,
                     mem_rw, PARK);
        else n_pass++;
`ifdef OAMDMA_DEBUG_PORTS_EN
        @(negedge clock);
        #1;
        n_checks++;
        if (done_cnt != 1) $display("FAIL %s_done_pulse: got %0d want 1", name, done_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_page_wrap();
        run_dma(8'hFF, 1'($urandom), 1'b0, "wrap");
        n_checks++;
        if (rd_addr.size() == 0 || rd_addr[rd_addr.size() - 1] !== 16'hFFFF)
            $display("FAIL wrap_last_addr: got %h want ffff",
                     (rd_addr.size() == 0) ? 16'hxxxx : rd_addr[rd_addr.size() - 1]);
        else n_pass++;
        n_checks++;
        if (saw_zero !== 1'b0) $display("FAIL wrap_zero_access: got %b want 0", saw_zero);
        else n_pass++;
    endtask

    task automatic test_reset_mid_dma();
        int w;
        @(posedge clock);
        #1;
        clear_log();
        cpu_rw = 1'b0;
        cpu_addr = DMA_REG;
        cpu_data_out = 8'h03;
        @(posedge clock);
        #1;
        park_cpu();
        w = 0;
        while (!(wr_data.size() == 99 && !mem_rw && mem_addr == OAM_REG) && w < 700) begin
            @(posedge clock);
            #1;
            w++;
        end
        n_checks++;
        if (w >= 700) $display("FAIL midreset_reach: got %0d writes want 99", wr_data.size());
        else n_pass++;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        n_checks++;
        if (cpu_halt !== 1'b0 || mem_addr !== cpu_addr || mem_rw !== cpu_rw)
            $display("FAIL midreset_idle: got %b/%h/%b want 0/%h/%b", cpu_halt, mem_addr,
                     mem_rw, cpu_addr, cpu_rw);
        else n_pass++;
        repeat (20) @(posedge clock);
        #1;
        n_checks++;
        if (wr_data.size() != 100 || cpu_halt !== 1'b0)
            $display("FAIL midreset_quiet: got %0d writes halt %b want 100 0", wr_data.size(),
                     cpu_halt);
        else n_pass++;
        run_dma(8'h04, 1'($urandom), 1'b0, "restart");
    endtask

    task automatic test_reset_and_trigger();
        @(posedge clock);
        #1;
        clear_log();
        reset = 1'b1;
        cpu_rw = 1'b0;
        cpu_addr = DMA_REG;
        cpu_data_out = 8'h06;
        @(posedge clock);
        #1;
        reset = 1'b0;
        park_cpu();
        n_checks++;
        if (cpu_halt !== 1'b0) $display("FAIL rst_trig_halt: got %b want 0", cpu_halt);
        else n_pass++;
        repeat (5) @(posedge clock);
        #1;
        n_checks++;
        if (cpu_halt !== 1'b0 || wr_data.size() != 0)
            $display("FAIL rst_trig_quiet: got halt %b writes %0d want 0 0", cpu_halt,
                     wr_data.size());
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_idle_passthrough();
        run_dma(8'h02, 1'b0, 1'b0, "even");
        run_dma(8'h02, 1'b1, 1'b0, "odd");
        test_page_wrap();
        test_reset_mid_dma();
        run_dma(8'h02, 1'($urandom), 1'b1, "retrig");
        run_dma(8'($urandom), 1'($urandom), 1'b0, "random");
        test_reset_and_trigger();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Owns the shared 16-bit memory bus between the cpu_2a03 core and the sprite (OAM) DMA engine.
- A CPU write to the DMA trigger register starts a 256-byte copy from page {page,8'h00} to the OAM data port; the CPU is halted while the copy runs.
- Sits between cpu_2a03 (addr/rw/data_out/data_in) and the memory/PPU-register decode.
- Owns bus parity (get/put cycle) tracking.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA; the data byte is the source page.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- cpu_addr  input  16  address from CPU.
- cpu_rw  input  1  CPU read(1)/write(0).
- cpu_data_out  input  8  CPU write data.
- cpu_halt  output  1  registered; 1 = CPU must freeze (bus not granted).
- mem_addr  output  16  arbitrated bus address.
- mem_rw  output  1  arbitrated read(1)/write(0).
- mem_data_out  output  8  arbitrated write data.
- mem_data_in  input  8  read data from memory, valid by the end of the same cycle (memory is clocked on ~clock).
- cpu_data_in  output  8  mem_data_in passed straight through to the CPU.

Behaviour:
- parity: 1-bit toggle, reset 0, flips every clock. parity=0 is a get (read) cycle; parity=1 is a put cycle.
- States: IDLE, HALT, ALIGN, READ, WRITE. Reset state is IDLE.
- Reset values: cpu_halt=0, idx=8'h00, page=8'h00, buf=8'h00. Mux outputs follow the IDLE passthrough.
- IDLE:
  - Bus mux is combinational passthrough: mem_addr=cpu_addr, mem_rw=cpu_rw, mem_data_out=cpu_data_out.
  - If cpu_rw=0 and cpu_addr=DMA_REG_ADDR at posedge: latch page<=cpu_data_out, idx<=0, cpu_halt<=1, go to HALT.
  - The trigger write itself completes normally to memory.
- HALT: one cycle. Dummy read: mem_addr=cpu_addr, mem_rw=1, mem_data_out=0.
  - Next state: READ if parity (sampled this cycle) = 1, so that READ lands on parity 0.
  - Otherwise ALIGN.
- ALIGN: one cycle, same dummy read as HALT, then go to READ.
- READ: mem_addr={page,idx}, mem_rw=1. Latch buf<=mem_data_in at posedge. Go to WRITE.
- WRITE: mem_addr=OAM_DATA_ADDR, mem_rw=0, mem_data_out=buf. idx<=idx+1 (8-bit).
  - If idx was 8'hFF: cpu_halt<=0, go to IDLE.
  - Otherwise go to READ.
- Latency: trigger cycle T. cpu_halt is high from T+1 through the last WRITE.
  - Total halted cycles = 513 (no ALIGN) or 514 (ALIGN).
  - The CPU regains the bus on the cycle after the last WRITE.
- READ always on parity 0, WRITE always on parity 1.
- Page 8'hFF: source addresses run 16'hFF00..16'hFFFF. idx wraps to 0, no carry into page.
- Triggers arriving while not IDLE are ignored; the CPU is halted, so its addr/rw are don't-care.
- Reset mid-DMA: next cycle is IDLE with cpu_halt=0, passthrough restored, and no further DMA writes.
- reset and a trigger in the same cycle: reset wins; no DMA starts.
- cpu_data_in = mem_data_in in all states. The CPU ignores it while halted.

Optional Feature:
- OAMDMA_DEBUG_PORTS_EN defined: adds these outputs:
  - dma_busy (1 bit): 1 whenever state != IDLE.
  - dma_index (8 bits): current idx.
  - dma_done (1 bit): registered one-cycle pulse on the cycle after the final WRITE.
  - All three reset to 0.
- Not defined: these ports and the dma_done register are absent; all other behaviour is identical.

Test Plan:
- Idle passthrough: CPU reads 16'h0821 holding 8'h31 -> mem_addr=16'h0821, mem_rw=1, cpu_data_in=8'h31, cpu_halt=0.
- Even start: write 8'h02 to 16'h4014 on parity 0 -> no ALIGN.
  - cpu_halt high for exactly 513 cycles.
  - 256 writes to 16'h2004 with data = mem[16'h0200..16'h02FF] in order.
  - READ cycles have parity 0.
- Odd start: same trigger on parity 1 -> ALIGN inserted, cpu_halt high for 514 cycles, identical data sequence.
- Page wrap: trigger with 8'hFF -> last READ address 16'hFFFF; no access to 16'h0000 follows; returns to IDLE.
- Reset mid-DMA: assert reset during the 100th WRITE -> next cycle cpu_halt=0, state IDLE, no further writes to 16'h2004; a later trigger restarts from idx 0.
- Re-trigger ignored: during DMA, force cpu_rw=0, cpu_addr=16'h4014, data 8'h05 -> page stays 8'h02 and the DMA completes unchanged.
